// File: rtl/mips_loader_pkg.sv
// Shared types for the instruction-memory program loader.
//   state_t : loader FSM states
//   wcnt_t  : 16-bit word count carried in the frame header
package mips_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    WORD   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  typedef logic [15:0] wcnt_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader for the MIPS instruction memory.
// Frame: N (16-bit big-endian), N x 32-bit big-endian words, then one
// checksum byte equal to the XOR of every preceding frame byte.
// The CPU is held (PC at 0) until the frame is loaded and verified.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle abort/restart pulse
//   in_valid/in_ready/in_data   host byte channel
//   im_we/im_addr/im_wdata      registered instruction-memory write port
//   cpu_hold          1 while the CPU must stay held
//   done              image loaded and checksum matched
//   err               oversize header or checksum mismatch (sticky)
module imem_loader
  import mips_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  state_t      state;
  wcnt_t       n;
  wcnt_t       wcnt;
  logic [1:0]  bcnt;
  logic [23:0] sh;
  logic [7:0]  xacc;
  logic        accept;
  logic [16:0] n_full;

  assign accept   = in_valid && in_ready;
  // Full header value as it becomes known on the low-byte accept.
  assign n_full   = {1'b0, n[15:8], in_data};

  assign in_ready = (state != DONE) && (state != ERR);
  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
  assign err      = (state == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HDR_HI;
      n        <= '0;
      wcnt     <= '0;
      bcnt     <= '0;
      sh       <= '0;
      xacc     <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
    end else begin
      im_we <= 1'b0;
      if (start) begin
        // Abort wins over a same-cycle byte; memory already written is kept.
        state <= HDR_HI;
        n     <= '0;
        wcnt  <= '0;
        bcnt  <= '0;
        xacc  <= '0;
      end else if (accept) begin
        xacc <= xacc ^ in_data;
        unique case (state)
          HDR_HI: begin
            n[15:8] <= in_data;
            state   <= HDR_LO;
          end
          HDR_LO: begin
            n[7:0] <= in_data;
            if (n_full > DEPTH)
              state <= ERR;
            else if (n_full == 17'd0)
              state <= CSUM;
            else
              state <= WORD;
          end
          WORD: begin
            sh   <= {sh[15:0], in_data};
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              im_we    <= 1'b1;
              im_addr  <= wcnt[ADDR_W-1:0];
              im_wdata <= {sh, in_data};
              wcnt     <= wcnt + 16'd1;
              if (wcnt + 16'd1 == n)
                state <= CSUM;
            end
          end
          CSUM: state <= (in_data == xacc) ? DONE : ERR;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] obs_q[$];
  logic [31:0]        wq[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Every cycle with the write strobe high becomes one observed write.
  always @(negedge clk) begin
    if (rst_n && im_we) obs_q.push_back({im_addr, im_wdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int unsigned k;
    k = 0;
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL handshake in_ready=%0b required=1 byte=%02h", in_ready, b);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Sends header, words from wq and checksum (XORed with corrupt); pushes expected writes.
  task automatic send_frame(input int unsigned n, input logic [7:0] corrupt, input bit gap);
    logic [7:0]  x;
    logic [15:0] n16;
    logic [31:0] w;
    n16 = n[15:0];
    x = n16[15:8] ^ n16[7:0];
    send_byte(n16[15:8], gap);
    send_byte(n16[7:0], gap);
    for (int i = 0; i < int'(n); i++) begin
      w = wq[i];
      exp_q.push_back({i[ADDR_W-1:0], w});
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      send_byte(w[31:24], gap);
      send_byte(w[23:16], gap);
      send_byte(w[15:8], gap);
      send_byte(w[7:0], gap);
    end
    send_byte(x ^ corrupt, gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    total++; if (im_we !== 1'b0) begin bad++; $display("FAIL rst_im_we got=%0b exp=0", im_we); end
    total++; if (im_addr !== '0) begin bad++; $display("FAIL rst_im_addr got=%0h exp=0", im_addr); end
    total++; if (im_wdata !== '0) begin bad++; $display("FAIL rst_im_wdata got=%0h exp=0", im_wdata); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_cpu_hold got=%0b exp=1", cpu_hold); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", err); end
  endtask

  task automatic test_basic(input bit gap);
    logic [ADDR_W+31:0] e, o;
    wq = '{32'h20080005, 32'h01094820};
    send_frame(2, 8'h00, gap);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic%0d_done got=%0b exp=1", gap, done); end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL basic%0d_hold got=%0b exp=0", gap, cpu_hold); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic%0d_ready got=%0b exp=0", gap, in_ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic%0d_err got=%0b exp=0", gap, err); end
    repeat (2) tick();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL basic%0d_nwrites got=%0d exp=%0d", gap, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL basic%0d_write got=%h exp=%h", gap, o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pulse_start();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    logic [7:0]  x;
    logic [ADDR_W+31:0] e, o;
    int unsigned strobes;
    strobes = 0;
    wq = '{32'hDEADBEEF, 32'h12345678, 32'hA5A55A5A};
    x = 8'h03;
    in_valid = 1'b1;
    in_data = 8'h00; tick();
    in_data = 8'h03; tick();
    for (int i = 0; i < 3; i++) begin
      w = wq[i];
      exp_q.push_back({i[ADDR_W-1:0], w});
      for (int j = 3; j >= 0; j--) begin
        in_data = w[j*8 +: 8];
        x = x ^ in_data;
        tick();
        if (im_we) strobes++;
        total++;
        if (im_we !== (j == 0)) begin
          bad++; $display("FAIL b2b_we_timing word=%0d byte=%0d got=%0b exp=%0b", i, 3 - j, im_we, (j == 0));
        end
      end
    end
    in_data = x; tick();
    in_valid = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%0b exp=1", done); end
    total++; if (strobes != 3) begin bad++; $display("FAIL b2b_strobes got=%0d exp=3", strobes); end
    repeat (2) tick();
    total++; if (obs_q.size() != 3) begin bad++; $display("FAIL b2b_nwrites got=%0d exp=3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL b2b_write got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pulse_start();
  endtask

  task automatic test_bad_csum();
    logic [ADDR_W+31:0] e, o;
    wq = '{32'h00000000};
    // Correct checksum is 0x01; 0x54 turns it into the wrong value 0x55.
    send_frame(1, 8'h54, 1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL csum_err got=%0b exp=1", err); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL csum_done got=%0b exp=0", done); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL csum_hold got=%0b exp=1", cpu_hold); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL csum_ready got=%0b exp=0", in_ready); end
    repeat (3) tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL csum_err_sticky got=%0b exp=1", err); end
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL csum_nwrites got=%0d exp=1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL csum_write got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pulse_start();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL csum_err_clear got=%0b exp=0", err); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL csum_ready_restart got=%0b exp=1", in_ready); end
  endtask

  task automatic test_oversize();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL over_err got=%0b exp=1", err); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL over_ready got=%0b exp=0", in_ready); end
    repeat (4) tick();
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL over_nwrites got=%0d exp=0", obs_q.size()); end
    obs_q.delete();
    pulse_start();
  endtask

  task automatic test_full();
    logic [ADDR_W+31:0] e, o;
    int unsigned n_ok;
    n_ok = 0;
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back({i[7:0], ~i[7:0], 8'h3C ^ i[7:0], i[7:0] + 8'h11});
    send_frame(256, 8'h00, 1'b0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done got=%0b exp=1", done); end
    repeat (2) tick();
    total++; if (obs_q.size() != 256) begin bad++; $display("FAIL full_nwrites got=%0d exp=256", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL full_write got=%h exp=%h", o, e); end
      else n_ok++;
    end
    total++; if (im_addr !== 8'hFF) begin bad++; $display("FAIL full_last_addr got=%0h exp=ff", im_addr); end
    exp_q.delete(); obs_q.delete();
    pulse_start();
  endtask

  task automatic test_zero();
    wq.delete();
    send_frame(0, 8'h00, 1'b0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%0b exp=1", done); end
    repeat (2) tick();
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL zero_nwrites got=%0d exp=0", obs_q.size()); end
    obs_q.delete();
    pulse_start();
  endtask

  task automatic test_abort();
    logic [ADDR_W+31:0] e, o;
    logic [31:0] w;
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int i = 0; i < 2; i++) begin
      w = 32'hC0DE0000 | i;
      exp_q.push_back({i[ADDR_W-1:0], w});
      for (int j = 3; j >= 0; j--) send_byte(w[j*8 +: 8], 1'b0);
    end
    send_byte(8'h77, 1'b0);
    // Start coincides with a valid byte: that byte must be dropped.
    in_valid = 1'b1; in_data = 8'h00;
    pulse_start();
    in_valid = 1'b0;
    repeat (2) tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%0b exp=1", in_ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%0b exp=0", done); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL abort_hold got=%0b exp=1", cpu_hold); end
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL abort_nwrites got=%0d exp=2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL abort_write got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    wq = '{32'h8C090004};
    send_frame(1, 8'h00, 1'b0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_done got=%0b exp=1", done); end
    repeat (2) tick();
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL restart_nwrites got=%0d exp=1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL restart_write got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pulse_start();
  endtask

  task automatic test_async_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hDC, 1'b0);
    send_byte(8'hBA, 1'b0);
    send_byte(8'h98, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    total++; if (im_wdata !== 32'hFEDCBA98) begin bad++; $display("FAIL ares_pre_wdata got=%h exp=fedcba98", im_wdata); end
    #2;
    rst_n = 1'b0;
    #1;
    test_reset();
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ares_after_ready got=%0b exp=1", in_ready); end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_back_to_back();
    test_bad_csum();
    test_oversize();
    test_full();
    test_zero();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
